sdf_bf_stage_4: RTL and testbench
=================================

Name: sdf_bf_stage_4

Overview:
- Radix-2 single-delay-feedback (SDF) decimation-in-frequency butterfly stage with a 4-deep feedback delay line.
- Sits directly downstream of the 8-point twiddle ROM stage and consumes its state code and twiddle pair (w_r, w_i) on the same cycle.
- Streams one complex 24-bit sample per in_valid cycle and produces one registered complex result per processing cycle for the next stage.

Parameters:
- DATA_W, 24, two's-complement width of each real/imag component (data and twiddle).
- FRAC_W, 8, fractional bits of twiddles; 1.0 = 256.
- DEPTH, 4, delay-line length (N/2 for this stage).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  din valid this cycle; same signal that drives the ROM stage
- din_r  in  DATA_W  input sample, real
- din_i  in  DATA_W  input sample, imag
- state  in  2  from ROM: 0 = fill, 1 = butterfly, 2 = twiddle; 3 is illegal
- w_r  in  DATA_W  twiddle real, valid when state = 2
- w_i  in  DATA_W  twiddle imag, valid when state = 2
- out_valid  out  1  dout valid
- dout_r  out  DATA_W  result, real
- dout_i  out  DATA_W  result, imag

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low. Reset clears the delay line, dout_r, dout_i and out_valid to 0.
- The delay line advances only on in_valid cycles. When in_valid = 0, all state holds and out_valid = 0 on the next cycle.
- The delay-line head (oldest entry, written DEPTH valid cycles earlier) is "a"; din is "b".
- state 0 (fill): push b; no output; out_valid = 0 next cycle.
- state 1 (butterfly):
  - dout <= a + b;
  - push a - b;
  - out_valid = 1 next cycle.
- state 2 (twiddle):
  - dout <= a × w, a complex product:
    - re = (ar·wr − ai·wi) >>> FRAC_W
    - im = (ar·wi + ai·wr) >>> FRAC_W
  - push b;
  - out_valid = 1 next cycle.
- state 3: treated as state 0 (push only, no output).
- Latency: 1 cycle, registered output, from the in_valid cycle to out_valid.
- After the initial 4 fill cycles, the ROM cycles 4× state 1 then 4× state 2 continuously. Output throughput is then 1 sample per valid cycle.
- Width and arithmetic rules:
  - Products are computed at full 2·DATA_W width.
  - Product sums are kept at 2·DATA_W+1 bits, then arithmetically shifted right by FRAC_W.
  - Results are truncated toward −∞ (floor) and the low DATA_W bits are kept.
  - Add/sub results wrap modulo 2^DATA_W; no saturation.
- Flush: the last 4 differences of a frame leave only when the next 4 in_valid cycles (state 2) arrive. Upstream must supply 4 trailing samples (zeros allowed) to drain the final frame.
- Reset asserted mid-frame: the delay line is discarded and out_valid drops immediately (async). The ROM resets concurrently, so the next frame restarts at fill.
- A din presented with in_valid = 0 is ignored.

Optional Feature:
- Macro SDF_BF_ROUND_EN.
- Defined: add 2^(FRAC_W−1) (= 128) to each twiddle-product sum before the shift, i.e. round half up.
- Undefined: plain floor truncation as above. Butterfly add/sub is unaffected either way.

Decomposition:
- Shared package fft_pkg:
  - DATA_W and FRAC_W constants
  - TW_ONE = 256
  - state encodings ST_FILL = 2'd0, ST_BF = 2'd1, ST_TW = 2'd2
  - a complex-sample struct typedef {re, im}
- One sub-module, cmul_q8: combinational complex multiply with shift and optional rounding. Reused by later stages.
- Delay line, mux and output registers live in the top.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream with out_valid = 1 → out_valid, dout_r and dout_i are 0 asynchronously; after release, 4 fill cycles produce no out_valid.
- DC frame: 8 samples (256, 0) followed by 4 zero samples:
  - 4 butterfly outputs of (512, 0);
  - then 4 twiddle outputs of (0, 0).
- Twiddle index 1: frame x1 = (256, 0), all other samples 0, plus 4 trailing zeros → outputs in order:
  - (0,0), (256,0), (0,0), (0,0)
  - (0,0), (181,−181), (0,0), (0,0)
- Twiddle index 3 and sign: x3 = (256, 0) → 8th output is (−181, −181); x2 = (0, 256) → 7th output is (256, 0).
- Stall: deassert in_valid for 3 cycles mid state 1 → no out_valid during the gap; after resuming, results are identical to the unstalled run.
- Rounding: x1 = (1, 0):
  - twiddle output (0, −1) without SDF_BF_ROUND_EN;
  - (1, −1) with it.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the SDF FFT pipeline stages.
// Twiddles are Q.8 fixed point: TW_ONE represents 1.0.
package fft_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned FRAC_W = 8;
  localparam int          TW_ONE = 256;

  // State codes presented by the twiddle ROM stage; 2'd3 is illegal
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BF   = 2'd1;
  localparam logic [1:0] ST_TW   = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cmul_q8.sv
// Combinational complex multiply a*w with a Q.FRAC_W twiddle, floor-shifted back to DATA_W.
// Define SDF_BF_ROUND_EN to round half up instead of flooring.
module cmul_q8 #(
  parameter int unsigned DATA_W = fft_pkg::DATA_W,
  parameter int unsigned FRAC_W = fft_pkg::FRAC_W
) (
  input  logic [DATA_W-1:0] a_r,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] w_r,
  input  logic [DATA_W-1:0] w_i,
  output logic [DATA_W-1:0] p_r,
  output logic [DATA_W-1:0] p_i
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned SW = PW + 1;

`ifdef SDF_BF_ROUND_EN
  localparam logic signed [SW-1:0] Rnd = SW'(1) << (FRAC_W - 1);
`endif

  logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;
  logic signed [PW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
  logic signed [SW-1:0] sum_r, sum_i;

  always_comb begin
    // Sign-extend first so the products are formed at full 2*DATA_W width
    ar_x = {{DATA_W{a_r[DATA_W-1]}}, a_r};
    ai_x = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    wr_x = {{DATA_W{w_r[DATA_W-1]}}, w_r};
    wi_x = {{DATA_W{w_i[DATA_W-1]}}, w_i};

    prod_rr = ar_x * wr_x;
    prod_ii = ai_x * wi_x;
    prod_ri = ar_x * wi_x;
    prod_ir = ai_x * wr_x;

    sum_r = {prod_rr[PW-1], prod_rr} - {prod_ii[PW-1], prod_ii};
    sum_i = {prod_ri[PW-1], prod_ri} + {prod_ir[PW-1], prod_ir};

`ifdef SDF_BF_ROUND_EN
    sum_r = sum_r + Rnd;
    sum_i = sum_i + Rnd;
`endif

    p_r = DATA_W'(sum_r >>> FRAC_W);
    p_i = DATA_W'(sum_i >>> FRAC_W);
  end

endmodule

// File: rtl/sdf_bf_stage_4.sv
// Radix-2 SDF DIF butterfly stage with a DEPTH-entry feedback delay line and registered output.
// Twiddle products round half up when SDF_BF_ROUND_EN is defined, otherwise they floor.
module sdf_bf_stage_4 #(
  parameter int unsigned DATA_W = fft_pkg::DATA_W,
  parameter int unsigned FRAC_W = fft_pkg::FRAC_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din_r,
  input  logic [DATA_W-1:0] din_i,
  input  logic [1:0]        state,
  input  logic [DATA_W-1:0] w_r,
  input  logic [DATA_W-1:0] w_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout_r,
  output logic [DATA_W-1:0] dout_i
);

  import fft_pkg::*;

  // Entry 0 is the newest push, entry DEPTH-1 the head ("a")
  logic [DEPTH-1:0][DATA_W-1:0] dl_r_q, dl_r_d;
  logic [DEPTH-1:0][DATA_W-1:0] dl_i_q, dl_i_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_W-1:0]            dout_r_q, dout_r_d;
  logic [DATA_W-1:0]            dout_i_q, dout_i_d;

  logic [DATA_W-1:0] a_r, a_i;
  logic [DATA_W-1:0] push_r, push_i;
  logic [DATA_W-1:0] tw_r, tw_i;

  assign a_r = dl_r_q[DEPTH-1];
  assign a_i = dl_i_q[DEPTH-1];

  cmul_q8 #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_cmul (
    .a_r (a_r),
    .a_i (a_i),
    .w_r (w_r),
    .w_i (w_i),
    .p_r (tw_r),
    .p_i (tw_i)
  );

  always_comb begin
    dl_r_d      = dl_r_q;
    dl_i_d      = dl_i_q;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    out_valid_d = 1'b0;
    push_r      = din_r;
    push_i      = din_i;

    if (in_valid) begin
      case (state)
        ST_BF: begin
          dout_r_d    = a_r + din_r;
          dout_i_d    = a_i + din_i;
          push_r      = a_r - din_r;
          push_i      = a_i - din_i;
          out_valid_d = 1'b1;
        end
        ST_TW: begin
          dout_r_d    = tw_r;
          dout_i_d    = tw_i;
          out_valid_d = 1'b1;
        end
        // Fill and the illegal code both just push din
        default: ;
      endcase
      dl_r_d = {dl_r_q[DEPTH-2:0], push_r};
      dl_i_d = {dl_i_q[DEPTH-2:0], push_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_r_q      <= '0;
      dl_i_q      <= '0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dl_r_q      <= dl_r_d;
      dl_i_q      <= dl_i_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_sdf_bf_stage_4.sv
// Scoreboard bench for sdf_bf_stage_4: directed 8-point frames with hand-computed results.
module tb_sdf_bf_stage_4;

  import fft_pkg::*;

  localparam int W = DATA_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] din_r = '0;
  logic [W-1:0] din_i = '0;
  logic [1:0]   state = ST_FILL;
  logic [W-1:0] w_r = '0;
  logic [W-1:0] w_i = '0;
  logic         out_valid;
  logic [W-1:0] dout_r;
  logic [W-1:0] dout_i;

  always #5 clk = ~clk;

  sdf_bf_stage_4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  cplx_t exp_q[$];
  cplx_t mon_e;
  cplx_t drv_e;
  int    checks = 0;
  int    errors = 0;

  int in_r[8];
  int in_i[8];
  int ex_r[8];
  int ex_i[8];
  int tw_r[4] = '{256, 181, 0, -181};
  int tw_i[4] = '{0, -181, -256, -181};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(req));
    end
  endtask

  // Monitor: every presented output must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got dout=(%0d,%0d), expected no output",
                 $signed(dout_r), $signed(dout_i));
      end else begin
        mon_e = exp_q.pop_front();
        check("dout_r", dout_r, mon_e.re);
        check("dout_i", dout_i, mon_e.im);
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Drives 8 frame samples plus 4 trailing zeros; optional 3-cycle stall before sample stall_at
  task automatic run_frame(input int stall_at, input int stop_at);
    for (int n = 0; n < 12; n++) begin
      if (n == stop_at) return;
      if (n == stall_at) begin
        repeat (3) begin
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          din_r    = 24'hABCDE;
          din_i    = 24'h12345;
          state    = ST_BF;
        end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      if (n < 8) begin
        din_r = W'(in_r[n]);
        din_i = W'(in_i[n]);
      end else begin
        din_r = '0;
        din_i = '0;
      end
      if (n < 4) begin
        state = ST_FILL;
      end else if (n < 8) begin
        state = ST_BF;
      end else begin
        state = ST_TW;
        w_r   = W'(tw_r[n-8]);
        w_i   = W'(tw_i[n-8]);
      end
      if (n >= 4) begin
        drv_e.re = W'(ex_r[n-4]);
        drv_e.im = W'(ex_i[n-4]);
        exp_q.push_back(drv_e);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_outputs: got %0d outputs still pending, expected 0", name,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", W'(out_valid), '0);
    check("reset_dout_r", dout_r, '0);
    check("reset_dout_i", dout_i, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // DC frame
    in_r = '{256, 256, 256, 256, 256, 256, 256, 256};
    in_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_r = '{512, 512, 512, 512, 0, 0, 0, 0};
    ex_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(-1, -1);
    drain_check("dc");

    // x1 = (256,0)
    do_reset();
    in_r = '{0, 256, 0, 0, 0, 0, 0, 0};
    in_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_r = '{0, 256, 0, 0, 0, 181, 0, 0};
    ex_i = '{0, 0, 0, 0, 0, -181, 0, 0};
    run_frame(-1, -1);
    drain_check("x1");

    // x3 = (256,0)
    do_reset();
    in_r = '{0, 0, 0, 256, 0, 0, 0, 0};
    in_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_r = '{0, 0, 0, 256, 0, 0, 0, -181};
    ex_i = '{0, 0, 0, 0, 0, 0, 0, -181};
    run_frame(-1, -1);
    drain_check("x3");

    // x2 = (0,256)
    do_reset();
    in_r = '{0, 0, 0, 0, 0, 0, 0, 0};
    in_i = '{0, 0, 256, 0, 0, 0, 0, 0};
    ex_r = '{0, 0, 0, 0, 0, 0, 256, 0};
    ex_i = '{0, 0, 256, 0, 0, 0, 0, 0};
    run_frame(-1, -1);
    drain_check("x2");

    // x1 frame with a 3-cycle stall in the butterfly phase
    do_reset();
    in_r = '{0, 256, 0, 0, 0, 0, 0, 0};
    in_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_r = '{0, 256, 0, 0, 0, 181, 0, 0};
    ex_i = '{0, 0, 0, 0, 0, -181, 0, 0};
    run_frame(6, -1);
    drain_check("stall");

    // Twiddle rounding on a small value
    do_reset();
    in_r = '{0, 1, 0, 0, 0, 0, 0, 0};
    in_i = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef SDF_BF_ROUND_EN
    ex_r = '{0, 1, 0, 0, 0, 1, 0, 0};
`else
    ex_r = '{0, 1, 0, 0, 0, 0, 0, 0};
`endif
    ex_i = '{0, 0, 0, 0, 0, -1, 0, 0};
    run_frame(-1, -1);
    drain_check("round");

    // Reset asserted while out_valid is high
    do_reset();
    in_r = '{256, 256, 256, 256, 256, 256, 256, 256};
    in_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_r = '{512, 512, 512, 512, 0, 0, 0, 0};
    ex_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(-1, 6);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", W'(out_valid), W'(1));
    check("pre_reset_dout_r", dout_r, W'(512));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("async_reset_out_valid", W'(out_valid), '0);
    check("async_reset_dout_r", dout_r, '0);
    check("async_reset_dout_i", dout_i, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Restart after reset must begin with 4 silent fill cycles
    in_r = '{0, 256, 0, 0, 0, 0, 0, 0};
    in_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex_r = '{0, 256, 0, 0, 0, 181, 0, 0};
    ex_i = '{0, 0, 0, 0, 0, -181, 0, 0};
    run_frame(-1, -1);
    drain_check("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
